weight_rom_sequencer: RTL and testbench
=======================================

Name: weight_rom_sequencer

Overview:
Controller that streams one layer's convolution coefficients from a single-port synchronous weight ROM into the downstream coefficient FIFO. It generates ROM addresses and read enables and absorbs the ROM's 1-cycle read latency through a 2-entry skid buffer. It honours FIFO backpressure and replays the full kernel a programmable number of passes per start.

Parameters:
KERN_SIZE, 9, number of coefficients in the ROM (>=1)
DATA_WIDTH, 16, coefficient width (matches `coeff_width)
REPEAT, 1, kernel passes per ap_start (>=1)
ADDR_WIDTH, max(1,$clog2(KERN_SIZE)), derived ROM address width

Ports:
ap_clk  in  1  clock
ap_rst  in  1  reset, synchronous and active-high
ap_start  in  1  level; sampled only in IDLE
ap_done  out  1  1-cycle pulse after the last word is written
ap_idle  out  1  high in IDLE
weight_V_address0  out  ADDR_WIDTH  ROM address
weight_V_ce0  out  1  ROM read enable; q valid the cycle after
weight_V_q0  in  DATA_WIDTH  ROM data
output_V_din  out  DATA_WIDTH  FIFO data
output_V_full_n  in  1  FIFO not full
output_V_write  out  1  FIFO write strobe

Behaviour:
- Reset values (cycle after ap_rst high): state IDLE, ap_idle=1, ap_done=0, weight_V_ce0=0, weight_V_address0=0, output_V_write=0, output_V_din=0, buffer empty, in-flight flag=0, address and pass counters=0.
- Reset mid-operation discards buffered and in-flight words. output_V_write=0 in every cycle where ap_rst=1.
- States:
  - IDLE: ap_start=1 moves to RUN next cycle.
  - RUN: issues reads until KERN_SIZE*REPEAT reads are issued, then moves to DRAIN.
  - DRAIN: waits until the buffer is empty and nothing is in flight, then moves to DONE.
  - DONE: ap_done=1 for one cycle, then IDLE.
- ap_start outside IDLE is ignored.
- Read issue: ce0=1 in a RUN cycle iff occupancy + inflight - pop < 2, where pop = output_V_write.
- Address: 0..KERN_SIZE-1. After KERN_SIZE-1 it wraps to 0 and the pass counter increments. The final read is address KERN_SIZE-1 of pass REPEAT-1.
- Capture: the word read in cycle n appears on q0 in cycle n+1 and is written into the buffer at the end of cycle n+1.
- Output: output_V_write = (buffer not empty) & output_V_full_n. output_V_din = buffer head; hold the last value when empty. A word transfers iff write=1.
- The buffer never overflows; a bench assertion checks occupancy <= 2.
- Latency: ap_start high in IDLE at cycle 0 gives first ce0 in cycle 1 and first write in cycle 3 (if full_n=1).
- Throughput: 1 word/cycle sustained while full_n=1. Total words per start = KERN_SIZE*REPEAT, in address order, repeated per pass.
- Backpressure: full_n=0 with 2 words buffered stops read issue. Words are never dropped or duplicated. Output resumes the cycle full_n returns high.
- ap_done occurs the cycle after the final write handshake.
- KERN_SIZE=1: address stays 0; ce0 still obeys the credit rule.

Optional Feature:
WEIGHT_SEQ_LOOP_EN
- Defined: after the final read of pass REPEAT-1, the address and pass counters wrap to 0 and RUN continues with no gap. DRAIN and DONE are never entered and ap_done stays 0. ap_idle is 1 only before the first ap_start after reset. This gives free-running behaviour for layers that consume weights per output tile.
- Undefined: behaviour as above.

Test Plan:
- KERN_SIZE=9, REPEAT=1, ROM[i]=i+0x10, full_n=1, start at cycle 0 -> ce0 in cycles 1..9 with addr 0..8; writes in cycles 3..11 with din 0x10..0x18; ap_done=1 in cycle 12; ap_idle=1 in cycle 13.
- Same config, full_n=0 during cycles 4..8 -> at most 2 reads outstanding; output order 0x10..0x18 unbroken; exactly 9 writes; ap_done the cycle after the 9th write.
- KERN_SIZE=4, REPEAT=3, full_n=1 -> 12 writes, addresses 0,1,2,3 repeated 3x with no idle cycles between passes; one ap_done.
- KERN_SIZE=9, ap_rst pulsed in cycle 6 while streaming -> all outputs at reset values the next cycle; no write in cycle 6; a new ap_start restarts from address 0 and yields 9 clean words.
- KERN_SIZE=1, REPEAT=5, full_n toggling every cycle -> 5 words equal to ROM[0]; ap_done once; ap_start held high during RUN is ignored.
- WEIGHT_SEQ_LOOP_EN defined, KERN_SIZE=3, REPEAT=2, full_n=1 -> continuous 0,1,2,0,1,2,... for 50 cycles; ap_done never asserted.

Source files
------------

// File: rtl/weight_rom_sequencer.sv
// Streams one kernel of coefficients from a sync weight ROM into a FIFO.
// Optional free-running mode: define WEIGHT_SEQ_LOOP_EN.
module weight_rom_sequencer #(
  parameter int KERN_SIZE  = 9,
  parameter int DATA_WIDTH = 16,
  parameter int REPEAT     = 1,
  parameter int ADDR_WIDTH = (KERN_SIZE > 1) ? $clog2(KERN_SIZE) : 1
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst,
  input  logic                  ap_start,
  output logic                  ap_done,
  output logic                  ap_idle,
  output logic [ADDR_WIDTH-1:0] weight_V_address0,
  output logic                  weight_V_ce0,
  input  logic [DATA_WIDTH-1:0] weight_V_q0,
  output logic [DATA_WIDTH-1:0] output_V_din,
  input  logic                  output_V_full_n,
  output logic                  output_V_write
);

  localparam int PASS_W = (REPEAT > 1) ? $clog2(REPEAT) : 1;
  localparam logic [ADDR_WIDTH-1:0] ADDR_LAST =
    ADDR_WIDTH'(KERN_SIZE - 1);
  localparam logic [PASS_W-1:0] PASS_LAST =
    PASS_W'(REPEAT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   addr;
  logic [PASS_W-1:0]       pass;
  logic                    inflight;
  logic [DATA_WIDTH-1:0]   mem [2];
  logic                    rd_ptr;
  logic                    wr_ptr;
  logic [1:0]              cnt;
  logic [DATA_WIDTH-1:0]   last_q;

  logic                    pop;
  logic                    issue;
  logic                    drain_ok;
  logic [2:0]              occ;
  logic [2:0]              net;

  // Credit check: never let buffered + in-flight words exceed two.
  always_comb begin
    pop      = 1'b0;
    issue    = 1'b0;
    drain_ok = 1'b0;
    occ      = 3'd0;
    net      = 3'd0;
    pop      = (cnt != 2'd0) && output_V_full_n && !ap_rst;
    occ      = {1'b0, cnt} + {2'b0, inflight};
    net      = occ - {2'b0, pop};
    issue    = (state == S_RUN) && !ap_rst && (net < 3'd2);
    drain_ok = !inflight && (cnt == {1'b0, pop});
  end

  assign weight_V_ce0      = issue;
  assign weight_V_address0 = addr;
  assign output_V_write    = pop;
  assign output_V_din      = (cnt != 2'd0) ? mem[rd_ptr] : last_q;
  assign ap_done           = (state == S_DONE);
  assign ap_idle           = (state == S_IDLE);

  // Control FSM with address and pass counters.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state <= S_IDLE;
      addr  <= '0;
      pass  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (ap_start) state <= S_RUN;
        end
        S_RUN: begin
          if (issue) begin
            if (addr == ADDR_LAST) begin
              addr <= '0;
              if (pass == PASS_LAST) begin
                pass <= '0;
`ifdef WEIGHT_SEQ_LOOP_EN
                state <= S_RUN;
`else
                state <= S_DRAIN;
`endif
              end else begin
                pass <= pass + 1'b1;
              end
            end else begin
              addr <= addr + 1'b1;
            end
          end
        end
        S_DRAIN: begin
          if (drain_ok) state <= S_DONE;
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Two-entry skid buffer absorbing the ROM read latency.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      inflight <= 1'b0;
      cnt      <= 2'd0;
      rd_ptr   <= 1'b0;
      wr_ptr   <= 1'b0;
      last_q   <= '0;
      mem[0]   <= '0;
      mem[1]   <= '0;
    end else begin
      inflight <= issue;
      if (inflight) begin
        mem[wr_ptr] <= weight_V_q0;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
        last_q <= mem[rd_ptr];
      end
      cnt <= cnt + {1'b0, inflight} - {1'b0, pop};
    end
  end

endmodule

// File: tb/tb_weight_rom_sequencer.sv
// Directed bench for weight_rom_sequencer.
// Three instances cover the kernel/repeat configurations.
module tb_weight_rom_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic        rst_a, start_a, full_a, done_a, idle_a, ce_a, wr_a;
  logic [3:0]  addr_a;
  logic [15:0] q_a, din_a;

  logic        rst_b, start_b, full_b, done_b, idle_b, ce_b, wr_b;
  logic [1:0]  addr_b;
  logic [15:0] q_b, din_b;

  logic        rst_c, start_c, full_c, done_c, idle_c, ce_c, wr_c;
  logic [0:0]  addr_c;
  logic [15:0] q_c, din_c;

  weight_rom_sequencer #(
    .KERN_SIZE(9), .DATA_WIDTH(16), .REPEAT(1)
  ) u_a (
    .ap_clk(clk), .ap_rst(rst_a), .ap_start(start_a),
    .ap_done(done_a), .ap_idle(idle_a),
    .weight_V_address0(addr_a), .weight_V_ce0(ce_a),
    .weight_V_q0(q_a), .output_V_din(din_a),
    .output_V_full_n(full_a), .output_V_write(wr_a)
  );

`ifdef WEIGHT_SEQ_LOOP_EN
  localparam int KB = 3;
  localparam int RB = 2;
`else
  localparam int KB = 4;
  localparam int RB = 3;
`endif

  weight_rom_sequencer #(
    .KERN_SIZE(KB), .DATA_WIDTH(16), .REPEAT(RB)
  ) u_b (
    .ap_clk(clk), .ap_rst(rst_b), .ap_start(start_b),
    .ap_done(done_b), .ap_idle(idle_b),
    .weight_V_address0(addr_b), .weight_V_ce0(ce_b),
    .weight_V_q0(q_b), .output_V_din(din_b),
    .output_V_full_n(full_b), .output_V_write(wr_b)
  );

  weight_rom_sequencer #(
    .KERN_SIZE(1), .DATA_WIDTH(16), .REPEAT(5)
  ) u_c (
    .ap_clk(clk), .ap_rst(rst_c), .ap_start(start_c),
    .ap_done(done_c), .ap_idle(idle_c),
    .weight_V_address0(addr_c), .weight_V_ce0(ce_c),
    .weight_V_q0(q_c), .output_V_din(din_c),
    .output_V_full_n(full_c), .output_V_write(wr_c)
  );

  // ROM models: ROM[i] = i + 0x10, one-cycle read latency.
  always @(posedge clk) begin
    if (ce_a) q_a <= 16'h10 + 16'(addr_a);
    if (ce_b) q_b <= 16'h10 + 16'(addr_b);
    if (ce_c) q_c <= 16'h10 + 16'(addr_c);
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Nominal run on u_a: start at cycle 0, full_n held high.
  task automatic run_nominal_a(input string tag);
    full_a = 1'b1;
    for (int c = 0; c < 15; c++) begin
      start_a = (c == 0);
      @(negedge clk);
      chk({tag, "_ce"}, 32'(ce_a), 32'(c >= 1 && c <= 9));
      if (c >= 1 && c <= 9)
        chk({tag, "_addr"}, 32'(addr_a), 32'(c - 1));
      chk({tag, "_wr"}, 32'(wr_a), 32'(c >= 3 && c <= 11));
      if (c >= 3 && c <= 11)
        chk({tag, "_din"}, 32'(din_a), 32'(16 + c - 3));
      chk({tag, "_done"}, 32'(done_a), 32'(c == 12));
      chk({tag, "_idle"}, 32'(idle_a), 32'(c == 0 || c >= 13));
      next_cycle();
    end
    start_a = 1'b0;
  endtask

  int nw, nr, ndone, last_wr, done_cyc;
  logic seen_done;

  initial begin
    rst_a = 1'b1; start_a = 1'b0; full_a = 1'b1;
    rst_b = 1'b1; start_b = 1'b0; full_b = 1'b1;
    rst_c = 1'b1; start_c = 1'b0; full_c = 1'b1;
    next_cycle();
    @(negedge clk);
    chk("rst_idle", 32'(idle_a), 32'd1);
    chk("rst_done", 32'(done_a), 32'd0);
    chk("rst_ce", 32'(ce_a), 32'd0);
    chk("rst_addr", 32'(addr_a), 32'd0);
    chk("rst_wr", 32'(wr_a), 32'd0);
    chk("rst_din", 32'(din_a), 32'd0);
    next_cycle();
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
    next_cycle();

`ifdef WEIGHT_SEQ_LOOP_EN
    for (int c = 0; c < 53; c++) begin
      start_b = (c == 0);
      @(negedge clk);
      chk("lp_done", 32'(done_b), 32'd0);
      chk("lp_idle", 32'(idle_b), 32'(c == 0));
      chk("lp_ce", 32'(ce_b), 32'(c >= 1));
      if (c >= 1)
        chk("lp_addr", 32'(addr_b), 32'((c - 1) % 3));
      chk("lp_wr", 32'(wr_b), 32'(c >= 3));
      if (c >= 3)
        chk("lp_din", 32'(din_b), 32'(16 + (c - 3) % 3));
      next_cycle();
    end
    start_b = 1'b0;
`else
    run_nominal_a("t1");

    nw = 0; nr = 0; ndone = 0; last_wr = -1; done_cyc = -1;
    for (int c = 0; c < 25; c++) begin
      start_a = (c == 0);
      full_a  = !(c >= 4 && c <= 8);
      @(negedge clk);
      if (ce_a) nr++;
      if (c >= 4 && c <= 8)
        chk("t2_stall", 32'(wr_a), 32'd0);
      if (wr_a) begin
        chk("t2_din", 32'(din_a), 32'(16 + nw));
        nw++;
        last_wr = c;
      end
      chk("t2_outst", 32'(nr - nw <= 2), 32'd1);
      if (done_a) begin
        ndone++;
        done_cyc = c;
      end
      next_cycle();
    end
    start_a = 1'b0; full_a = 1'b1;
    chk("t2_reads", 32'(nr), 32'd9);
    chk("t2_writes", 32'(nw), 32'd9);
    chk("t2_lastwr", 32'(last_wr), 32'd16);
    chk("t2_donecyc", 32'(done_cyc), 32'd17);
    chk("t2_ndone", 32'(ndone), 32'd1);

    for (int c = 0; c < 20; c++) begin
      start_b = (c == 0);
      @(negedge clk);
      chk("t3_ce", 32'(ce_b), 32'(c >= 1 && c <= 12));
      if (c >= 1 && c <= 12)
        chk("t3_addr", 32'(addr_b), 32'((c - 1) % 4));
      chk("t3_wr", 32'(wr_b), 32'(c >= 3 && c <= 14));
      if (c >= 3 && c <= 14)
        chk("t3_din", 32'(din_b), 32'(16 + (c - 3) % 4));
      chk("t3_done", 32'(done_b), 32'(c == 15));
      next_cycle();
    end
    start_b = 1'b0;

    for (int c = 0; c < 8; c++) begin
      start_a = (c == 0);
      rst_a   = (c == 6);
      @(negedge clk);
      if (c >= 3 && c <= 5) begin
        chk("t4_wr", 32'(wr_a), 32'd1);
        chk("t4_din", 32'(din_a), 32'(16 + c - 3));
      end
      if (c == 6) chk("t4_rstwr", 32'(wr_a), 32'd0);
      if (c == 7) begin
        chk("t4_idle", 32'(idle_a), 32'd1);
        chk("t4_done", 32'(done_a), 32'd0);
        chk("t4_ce", 32'(ce_a), 32'd0);
        chk("t4_addr", 32'(addr_a), 32'd0);
        chk("t4_wr7", 32'(wr_a), 32'd0);
        chk("t4_din7", 32'(din_a), 32'd0);
      end
      next_cycle();
    end
    rst_a = 1'b0;
    run_nominal_a("t4r");

    nw = 0; nr = 0; ndone = 0; seen_done = 1'b0;
    for (int c = 0; c < 60; c++) begin
      start_c = !seen_done;
      full_c  = (c % 2 == 0);
      @(negedge clk);
      if (ce_c) begin
        nr++;
        chk("t5_addr", 32'(addr_c), 32'd0);
      end
      if (wr_c) begin
        nw++;
        chk("t5_din", 32'(din_c), 32'h10);
      end
      chk("t5_outst", 32'(nr - nw <= 2), 32'd1);
      if (done_c) begin
        ndone++;
        seen_done = 1'b1;
      end
      next_cycle();
    end
    start_c = 1'b0;
    @(negedge clk);
    chk("t5_reads", 32'(nr), 32'd5);
    chk("t5_writes", 32'(nw), 32'd5);
    chk("t5_ndone", 32'(ndone), 32'd1);
    chk("t5_idle", 32'(idle_c), 32'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
